gray_counter_param: RTL and testbench

- Parametrised N-bit Gray-code counter. Generalises the team's fixed 3-bit Gray counter.
- Adds up/down counting, parallel load, a selectable wrap or saturate mode, and separate sticky overflow and underflow flags with a clear input.
- Also outputs the binary equivalent of the count.
- Used as a general sequence and pointer source, e.g. for FIFO pointers and step counters in later lab datapaths.

---
 rtl/gray_counter_param.sv | 133 +++++++++++++
 tb/tb_gray_counter_param.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
// -----------------------------------------------------------------------------
// gray_counter_param
//
// Purpose:
//   Parametrised WIDTH-bit Gray-code counter with up/down counting, parallel
//   load (binary), selectable wrap or saturate behaviour at the range ends,
//   sticky overflow/underflow flags with a clear input, and a one-cycle wrap
//   pulse. The count is held internally in binary; the Gray output is derived
//   from the next binary value so both outputs are registered on the same edge.
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   SATURATE  0 = wrap at the range ends, 1 = hold at the end value
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   En         in   count enable, one step per enabled edge
//   Dir        in   0 = up, 1 = down
//   Load       in   parallel load strobe (beats En)
//   LoadVal    in   [WIDTH-1:0] binary value to load
//   ClrFlag    in   clears Overflow and Underflow
//   Output     out  [WIDTH-1:0] count in Gray code
//   Binary     out  [WIDTH-1:0] count in binary
//   Overflow   out  sticky, set when an up-step leaves the maximum
//   Underflow  out  sticky, set when a down-step leaves zero
//   Wrap       out  one-cycle pulse on an edge where the count wraps
// -----------------------------------------------------------------------------
module gray_counter_param #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned SATURATE = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Dir,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ClrFlag,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Binary,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Wrap
);

   localparam logic             SAT_MODE = (SATURATE != 0);
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Binary to reflected Gray code conversion.
   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_ovf;
   logic             r_unf;
   logic             r_wrap;

   logic [WIDTH-1:0] w_bin_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;
   logic             w_wrap_nxt;

   // Next-state logic: Load beats En; ClrFlag is applied first so that a
   // boundary event on the same edge re-sets its own flag afterwards.
   always_comb begin
      w_bin_nxt  = r_bin;
      w_wrap_nxt = 1'b0;
      w_ovf_nxt  = r_ovf & ~ClrFlag;
      w_unf_nxt  = r_unf & ~ClrFlag;

      if (Load) begin
         w_bin_nxt = LoadVal;
      end else if (En) begin
         if (!Dir) begin
            if (r_bin == CNT_MAX) begin
               w_ovf_nxt = 1'b1;
               if (SAT_MODE) begin
                  w_bin_nxt = r_bin;
               end else begin
                  w_bin_nxt  = CNT_ZERO;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin + CNT_ONE;
            end
         end else begin
            if (r_bin == CNT_ZERO) begin
               w_unf_nxt = 1'b1;
               if (SAT_MODE) begin
                  w_bin_nxt = r_bin;
               end else begin
                  w_bin_nxt  = CNT_MAX;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin - CNT_ONE;
            end
         end
      end else begin
         w_bin_nxt = r_bin;
      end
   end

   // State and output registers; Gray is computed from the next binary value
   // so Output and Binary always describe the same count.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_bin  <= CNT_ZERO;
         r_gray <= CNT_ZERO;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= to_gray(w_bin_nxt);
         r_ovf  <= w_ovf_nxt;
         r_unf  <= w_unf_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign Output    = r_gray;
   assign Binary    = r_bin;
   assign Overflow  = r_ovf;
   assign Underflow = r_unf;
   assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (W3 wrap, W3 saturate,
// W5 wrap) share one stimulus bus. Each drive pushes the expected state of
// all three instances onto a queue; tasks pop and compare after the edge,
// and also check the literal values listed for each scenario.
module tb_gray_counter_param;

   logic        Clk;
   logic        Reset;
   logic        En;
   logic        Dir;
   logic        Load;
   logic        ClrFlag;
   logic [15:0] LoadVal;

   logic [2:0] g3a, b3a;
   logic       ov3a, un3a, wr3a;
   logic [2:0] g3s, b3s;
   logic       ov3s, un3s, wr3s;
   logic [4:0] g5, b5;
   logic       ov5, un5, wr5;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] bin;
      logic        ovf;
      logic        unf;
      logic        wrap;
   } st_t;

   st_t m_a, m_s, m_5;
   logic [30:0] sb_q[$];

   gray_counter_param #(.WIDTH(3), .SATURATE(0)) dut_w3 (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadVal(LoadVal[2:0]), .ClrFlag(ClrFlag), .Output(g3a), .Binary(b3a),
      .Overflow(ov3a), .Underflow(un3a), .Wrap(wr3a));

   gray_counter_param #(.WIDTH(3), .SATURATE(1)) dut_w3s (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadVal(LoadVal[2:0]), .ClrFlag(ClrFlag), .Output(g3s), .Binary(b3s),
      .Overflow(ov3s), .Underflow(un3s), .Wrap(wr3s));

   gray_counter_param #(.WIDTH(5), .SATURATE(0)) dut_w5 (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadVal(LoadVal[4:0]), .ClrFlag(ClrFlag), .Output(g5), .Binary(b5),
      .Overflow(ov5), .Underflow(un5), .Wrap(wr5));

   always #5 Clk = ~Clk;

   // Reference behaviour of one counter for one edge.
   function automatic st_t mstep(input st_t s, input int w, input bit sat,
                                 input bit rst, input bit en, input bit dir,
                                 input bit ld, input logic [15:0] ldv,
                                 input bit clr);
      logic [15:0] mx;
      st_t n;
      mx = (16'h1 << w) - 16'h1;
      n = s;
      n.wrap = 1'b0;
      if (clr) begin
         n.ovf = 1'b0;
         n.unf = 1'b0;
      end
      if (rst) begin
         n = '0;
      end else if (ld) begin
         n.bin = ldv & mx;
      end else if (en && !dir) begin
         if (s.bin == mx) begin
            n.ovf = 1'b1;
            if (!sat) begin n.bin = 16'h0; n.wrap = 1'b1; end
         end else n.bin = s.bin + 16'h1;
      end else if (en && dir) begin
         if (s.bin == 16'h0) begin
            n.unf = 1'b1;
            if (!sat) begin n.bin = mx; n.wrap = 1'b1; end
         end else n.bin = s.bin - 16'h1;
      end
      return n;
   endfunction

   function automatic logic [15:0] gray_of(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [30:0] pack_exp(input st_t a, input st_t s, input st_t c);
      logic [15:0] ga, gs, gc;
      ga = gray_of(a.bin);
      gs = gray_of(s.bin);
      gc = gray_of(c.bin);
      return {ga[2:0], a.bin[2:0], a.ovf, a.unf, a.wrap,
              gs[2:0], s.bin[2:0], s.ovf, s.unf, s.wrap,
              gc[4:0], c.bin[4:0], c.ovf, c.unf, c.wrap};
   endfunction

   function automatic logic [30:0] obs_vec();
      return {g3a, b3a, ov3a, un3a, wr3a,
              g3s, b3s, ov3s, un3s, wr3s,
              g5, b5, ov5, un5, wr5};
   endfunction

   // Drive one edge and push the expected results of all three counters.
   task automatic tick(input bit rst, input bit en, input bit dir, input bit ld,
                       input logic [15:0] ldv, input bit clr);
      Reset = rst; En = en; Dir = dir; Load = ld; LoadVal = ldv; ClrFlag = clr;
      m_a = mstep(m_a, 3, 1'b0, rst, en, dir, ld, ldv, clr);
      m_s = mstep(m_s, 3, 1'b1, rst, en, dir, ld, ldv, clr);
      m_5 = mstep(m_5, 5, 1'b0, rst, en, dir, ld, ldv, clr);
      sb_q.push_back(pack_exp(m_a, m_s, m_5));
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [30:0] e;
      tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h5, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
         failures++;
         $display("FAIL reset_sb got=%h want=%h", obs_vec(), e);
      end
      checks++;
      if ({g3a, b3a, ov3a, un3a, wr3a, g5, b5, ov5, un5, wr5} !== 26'h0) begin
         failures++;
         $display("FAIL reset_zero got g3=%b b3=%b g5=%b b5=%b flags=%b%b%b want all 0",
                  g3a, b3a, g5, b5, ov3a, un3a, wr3a);
      end
   endtask

   task automatic test_count_up();
      logic [30:0] e;
      logic [2:0]  exp_g[9];
      logic [2:0]  prev;
      exp_g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      prev = g3a;
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (obs_vec() !== e) begin
            failures++;
            $display("FAIL up_sb edge=%0d got=%h want=%h", i + 1, obs_vec(), e);
         end
         checks++;
         if (g3a !== exp_g[i] || ov3a !== (i >= 7) || wr3a !== (i == 7)) begin
            failures++;
            $display("FAIL up_seq edge=%0d got g=%b ovf=%b wrap=%b want g=%b ovf=%b wrap=%b",
                     i + 1, g3a, ov3a, wr3a, exp_g[i], (i >= 7), (i == 7));
         end
         checks++;
         if ($countones(prev ^ g3a) != 1) begin
            failures++;
            $display("FAIL up_hamming edge=%0d got prev=%b cur=%b want distance 1", i + 1, prev, g3a);
         end
         prev = g3a;
      end
   endtask

   task automatic test_count_down();
      logic [30:0] e;
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
         failures++;
         $display("FAIL down_wrap_sb got=%h want=%h", obs_vec(), e);
      end
      checks++;
      if (g3a !== 3'b100 || b3a !== 3'd7 || un3a !== 1'b1 || wr3a !== 1'b1) begin
         failures++;
         $display("FAIL down_wrap got g=%b b=%0d unf=%b wrap=%b want g=100 b=7 unf=1 wrap=1",
                  g3a, b3a, un3a, wr3a);
      end
      tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e || g3a !== 3'b101 || wr3a !== 1'b0) begin
         failures++;
         $display("FAIL down_step got g=%b wrap=%b vec=%h want g=101 wrap=0 vec=%h",
                  g3a, wr3a, obs_vec(), e);
      end
   endtask

   task automatic test_saturate();
      logic [30:0] e;
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h6, 1'b0);
      e = sb_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (obs_vec() !== e || b3s !== 3'd7 || g3s !== 3'b100 || wr3s !== 1'b0) begin
            failures++;
            $display("FAIL sat_up edge=%0d got b=%0d g=%b wrap=%b want b=7 g=100 wrap=0",
                     i + 1, b3s, g3s, wr3s);
         end
      end
      checks++;
      if (ov3s !== 1'b1) begin
         failures++;
         $display("FAIL sat_ovf got=%b want=1", ov3s);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e || b3s !== 3'd0 || un3s !== 1'b1 || wr3s !== 1'b0) begin
         failures++;
         $display("FAIL sat_down got b=%0d unf=%b wrap=%b want b=0 unf=1 wrap=0", b3s, un3s, wr3s);
      end
   endtask

   task automatic test_load_priority();
      logic [30:0] e;
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h7, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b0, 1'b1, 16'h5, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
         failures++;
         $display("FAIL load_sb got=%h want=%h", obs_vec(), e);
      end
      checks++;
      if (b3a !== 3'd5 || g3a !== 3'b111 || ov3a !== 1'b1 || wr3a !== 1'b0) begin
         failures++;
         $display("FAIL load_en got b=%0d g=%b ovf=%b wrap=%b want b=5 g=111 ovf=1 wrap=0",
                  b3a, g3a, ov3a, wr3a);
      end
   endtask

   task automatic test_clrflag();
      logic [30:0] e;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e || ov3a !== 1'b0 || un3a !== 1'b0) begin
         failures++;
         $display("FAIL clr_alone got ovf=%b unf=%b want 0 0", ov3a, un3a);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
         failures++;
         $display("FAIL clr_event_sb got=%h want=%h", obs_vec(), e);
      end
      checks++;
      if (ov3a !== 1'b1 || un3a !== 1'b0 || wr3a !== 1'b1 || b3a !== 3'd0) begin
         failures++;
         $display("FAIL clr_event got ovf=%b unf=%b wrap=%b b=%0d want ovf=1 unf=0 wrap=1 b=0",
                  ov3a, un3a, wr3a, b3a);
      end
   endtask

   task automatic test_w5_hamming();
      logic [30:0] e;
      logic [4:0]  prev;
      tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      e = sb_q.pop_front();
      prev = g5;
      for (int i = 1; i <= 40; i++) begin
         tick((i == 20), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (obs_vec() !== e) begin
            failures++;
            $display("FAIL w5_sb edge=%0d got=%h want=%h", i, obs_vec(), e);
         end
         checks++;
         if (i == 20) begin
            if (g5 !== 5'd0 || b5 !== 5'd0 || ov5 !== 1'b0 || un5 !== 1'b0 || wr5 !== 1'b0) begin
               failures++;
               $display("FAIL w5_reset got g=%b b=%b flags=%b%b%b want zeros", g5, b5, ov5, un5, wr5);
            end
         end else if ($countones(prev ^ g5) != 1) begin
            failures++;
            $display("FAIL w5_hamming edge=%0d got prev=%b cur=%b want distance 1", i, prev, g5);
         end
         prev = g5;
      end
   endtask

   task automatic test_random();
      logic [30:0] e;
      for (int i = 0; i < 200; i++) begin
         tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 7) == 0));
         e = sb_q.pop_front();
         checks++;
         if (obs_vec() !== e) begin
            failures++;
            $display("FAIL random_sb step=%0d got=%h want=%h", i, obs_vec(), e);
         end
      end
   endtask

   initial begin
      Clk = 1'b0; Reset = 1'b0; En = 1'b0; Dir = 1'b0; Load = 1'b0;
      ClrFlag = 1'b0; LoadVal = 16'h0;
      m_a = '0; m_s = '0; m_5 = '0;
      #2;
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_load_priority();
      test_clrflag();
      test_w5_hamming();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
